result_display_driver: RTL and testbench

Downstream display stage of the calculator datapath. Takes an 8-bit operand or result plus sign/overflow qualifiers, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives four registered seven-segment outputs: sign, hundreds, tens and units. Load/Busy/Done handshake with the calculator control FSM; one instance per displayed value (A, B, result).

---
 rtl/result_display_driver_if.sv | 24 ++
 rtl/result_display_driver.sv | 147 ++++++++++++++
 tb/tb_result_display_driver.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/result_display_driver_if.sv
// rtl/result_display_driver_if.sv - load/busy/done handshake and segment bus of the display driver
interface result_display_driver_if;
  logic [7:0] Value;
  logic       Signed;
  logic       Overflow;
  logic       Load;
  logic       Blank;
  logic       Busy;
  logic       Done;
  logic [7:0] SSegSign;
  logic [7:0] SSegHundreds;
  logic [7:0] SSegTens;
  logic [7:0] SSegUnits;

  modport master (
    output Value, Signed, Overflow, Load, Blank,
    input  Busy, Done, SSegSign, SSegHundreds, SSegTens, SSegUnits
  );

  modport slave (
    input  Value, Signed, Overflow, Load, Blank,
    output Busy, Done, SSegSign, SSegHundreds, SSegTens, SSegUnits
  );
endinterface

// File: rtl/result_display_driver.sv
// rtl/result_display_driver.sv - 8-bit value to sign + 3 BCD seven-segment digits via sequential double-dabble
module result_display_driver #(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic                    clock,
  input logic                    reset,
  result_display_driver_if.slave bus
);

  // Patterns below are written active-low; PM flips them for active-high boards.
  localparam logic [7:0] PM      = ACTIVE_LOW ? 8'h00 : 8'hFF;
  localparam logic [7:0] SEG_BLK = 8'hFF ^ PM;
  localparam logic [7:0] SEG_MIN = 8'hBF ^ PM;
  localparam logic [7:0] SEG_E   = 8'h86 ^ PM;
  localparam logic [7:0] SEG_R   = 8'hAF ^ PM;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  iter_q;
  logic [7:0]  mag_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;
  logic        neg_q, ovf_q, done_q;
  logic [7:0]  disp_s_q, disp_h_q, disp_t_q, disp_u_q;
  logic [7:0]  out_s_q, out_h_q, out_t_q, out_u_q;
  logic [7:0]  new_s, new_h, new_t, new_u;
  logic [3:0]  dig_h, dig_t, dig_u;

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'hC0;
      4'd1:    p = 8'hF9;
      4'd2:    p = 8'hA4;
      4'd3:    p = 8'hB0;
      4'd4:    p = 8'h99;
      4'd5:    p = 8'h92;
      4'd6:    p = 8'h82;
      4'd7:    p = 8'hF8;
      4'd8:    p = 8'h80;
      4'd9:    p = 8'h90;
      default: p = 8'hFF;
    endcase
    return p ^ PM;
  endfunction

  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Load) state_d = bus.Overflow ? UPDATE : CONVERT;
      CONVERT: if (iter_q == 3'd7) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = {adj(bcd_q[11:8]), adj(bcd_q[7:4]), adj(bcd_q[3:0])};
    dig_h   = bcd_q[11:8];
    dig_t   = bcd_q[7:4];
    dig_u   = bcd_q[3:0];
    new_s   = (neg_q && !ovf_q) ? SEG_MIN : SEG_BLK;
    new_h   = ovf_q ? SEG_E : seg(dig_h);
    new_t   = ovf_q ? SEG_R : seg(dig_t);
    new_u   = ovf_q ? SEG_R : seg(dig_u);
    // Tens is only leading when the hundreds digit is also zero.
    if (!ovf_q && BLANK_LEADING && dig_h == 4'd0) begin
      new_h = SEG_BLK;
      if (dig_t == 4'd0) new_t = SEG_BLK;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iter_q   <= 3'd0;
      mag_q    <= 8'd0;
      bcd_q    <= 12'd0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      disp_s_q <= SEG_BLK;
      disp_h_q <= SEG_BLK;
      disp_t_q <= SEG_BLK;
      disp_u_q <= SEG_BLK;
      out_s_q  <= SEG_BLK;
      out_h_q  <= SEG_BLK;
      out_t_q  <= SEG_BLK;
      out_u_q  <= SEG_BLK;
    end else begin
      done_q <= (state_q == UPDATE);
      if (state_q == IDLE && bus.Load) begin
        neg_q  <= bus.Signed & bus.Value[7];
        // -128 negates to 0x80, which still reads correctly as unsigned 128.
        mag_q  <= (bus.Signed & bus.Value[7]) ? ~bus.Value + 8'd1 : bus.Value;
        ovf_q  <= bus.Overflow;
        bcd_q  <= 12'd0;
        iter_q <= 3'd0;
      end
      if (state_q == CONVERT) begin
        bcd_q  <= {bcd_adj[10:0], mag_q[7]};
        mag_q  <= {mag_q[6:0], 1'b0};
        iter_q <= iter_q + 3'd1;
      end
      if (state_q == UPDATE) begin
        disp_s_q <= new_s;
        disp_h_q <= new_h;
        disp_t_q <= new_t;
        disp_u_q <= new_u;
      end
      if (bus.Blank) begin
        out_s_q <= SEG_BLK;
        out_h_q <= SEG_BLK;
        out_t_q <= SEG_BLK;
        out_u_q <= SEG_BLK;
      end else if (state_q == UPDATE) begin
        out_s_q <= new_s;
        out_h_q <= new_h;
        out_t_q <= new_t;
        out_u_q <= new_u;
      end else begin
        out_s_q <= disp_s_q;
        out_h_q <= disp_h_q;
        out_t_q <= disp_t_q;
        out_u_q <= disp_u_q;
      end
    end
  end

  assign bus.Busy         = (state_q != IDLE);
  assign bus.Done         = done_q;
  assign bus.SSegSign     = out_s_q;
  assign bus.SSegHundreds = out_h_q;
  assign bus.SSegTens     = out_t_q;
  assign bus.SSegUnits    = out_u_q;

endmodule

// File: tb/tb_result_display_driver.sv
// tb/tb_result_display_driver.sv - directed vector bench for result_display_driver
module tb_result_display_driver;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value = 8'd0;
  logic       sgn   = 1'b0;
  logic       ovf   = 1'b0;
  logic       load  = 1'b0;
  logic       blank = 1'b0;
  int         total = 0;
  int         bad   = 0;

  always #5 clock = ~clock;

  result_display_driver_if b1 ();
  result_display_driver_if b2 ();
  result_display_driver_if b3 ();

  assign b1.Value = value;  assign b2.Value = value;  assign b3.Value = value;
  assign b1.Signed = sgn;   assign b2.Signed = sgn;   assign b3.Signed = sgn;
  assign b1.Overflow = ovf; assign b2.Overflow = ovf; assign b3.Overflow = ovf;
  assign b1.Load = load;    assign b2.Load = load;    assign b3.Load = load;
  assign b1.Blank = blank;  assign b2.Blank = blank;  assign b3.Blank = blank;

  result_display_driver dut (.clock(clock), .reset(reset), .bus(b1));
  result_display_driver #(.ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_nb (.clock(clock), .reset(reset), .bus(b2));
  result_display_driver #(.ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) dut_ah (.clock(clock), .reset(reset), .bus(b3));

  typedef struct {
    logic [7:0] v;
    logic       s;
    logic       o;
    int         lat;
    logic [7:0] es, eh, et, eu;
    logic [7:0] nh, nt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [7:0] s, input logic [7:0] h,
                            input logic [7:0] t, input logic [7:0] u);
    check({tag, " sign"}, b1.SSegSign, s);
    check({tag, " hundreds"}, b1.SSegHundreds, h);
    check({tag, " tens"}, b1.SSegTens, t);
    check({tag, " units"}, b1.SSegUnits, u);
  endtask

  task automatic do_load(input logic [7:0] v, input logic s, input logic o);
    value = v; sgn = s; ovf = o; load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (b1.Done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && (b1.Busy || b1.Done); k++) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    vecs[0]  = '{8'd0,   1'b0, 1'b0, 9, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0};
    vecs[1]  = '{8'd255, 1'b0, 1'b0, 9, 8'hFF, 8'hA4, 8'h92, 8'h92, 8'hA4, 8'h92};
    vecs[2]  = '{8'd7,   1'b0, 1'b0, 9, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hC0, 8'hC0};
    vecs[3]  = '{8'h80,  1'b1, 1'b0, 9, 8'hBF, 8'hF9, 8'hA4, 8'h80, 8'hF9, 8'hA4};
    vecs[4]  = '{8'hFF,  1'b1, 1'b0, 9, 8'hBF, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0};
    vecs[5]  = '{8'd77,  1'b0, 1'b1, 1, 8'hFF, 8'h86, 8'hAF, 8'hAF, 8'h86, 8'hAF};
    vecs[6]  = '{8'd5,   1'b0, 1'b0, 9, 8'hFF, 8'hFF, 8'hFF, 8'h92, 8'hC0, 8'hC0};
    vecs[7]  = '{8'd42,  1'b0, 1'b0, 9, 8'hFF, 8'hFF, 8'h99, 8'hA4, 8'hC0, 8'h99};
    vecs[8]  = '{8'd123, 1'b0, 1'b0, 9, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'hF9, 8'hA4};
    vecs[9]  = '{8'h80,  1'b0, 1'b0, 9, 8'hFF, 8'hF9, 8'hA4, 8'h80, 8'hF9, 8'hA4};
    vecs[10] = '{8'd100, 1'b0, 1'b0, 9, 8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hF9, 8'hC0};
    vecs[11] = '{8'hF6,  1'b1, 1'b0, 9, 8'hBF, 8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hF9};
    vecs[12] = '{8'h7F,  1'b1, 1'b0, 9, 8'hFF, 8'hF9, 8'hA4, 8'hF8, 8'hF9, 8'hA4};

    repeat (3) @(posedge clock);
    #1;
    check("reset busy", {7'd0, b1.Busy}, 8'd0);
    check("reset done", {7'd0, b1.Done}, 8'd0);
    check_disp("reset", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("reset active-high units", b3.SSegUnits, 8'h00);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 13; i++) begin
      do_load(vecs[i].v, vecs[i].s, vecs[i].o);
      check($sformatf("v%0d busy after load", i), {7'd0, b1.Busy}, 8'd1);
      wait_done(lat);
      check($sformatf("v%0d latency", i), 8'(lat), 8'(vecs[i].lat));
      check($sformatf("v%0d busy at done", i), {7'd0, b1.Busy}, 8'd0);
      check($sformatf("v%0d done no-lead", i), {7'd0, b2.Done}, 8'd1);
      check_disp($sformatf("v%0d", i), vecs[i].es, vecs[i].eh, vecs[i].et, vecs[i].eu);
      check($sformatf("v%0d no-lead sign", i), b2.SSegSign, vecs[i].es);
      check($sformatf("v%0d no-lead hundreds", i), b2.SSegHundreds, vecs[i].nh);
      check($sformatf("v%0d no-lead tens", i), b2.SSegTens, vecs[i].nt);
      check($sformatf("v%0d no-lead units", i), b2.SSegUnits, vecs[i].eu);
      check($sformatf("v%0d act-high sign", i), b3.SSegSign, ~vecs[i].es);
      check($sformatf("v%0d act-high hundreds", i), b3.SSegHundreds, ~vecs[i].eh);
      check($sformatf("v%0d act-high tens", i), b3.SSegTens, ~vecs[i].et);
      check($sformatf("v%0d act-high units", i), b3.SSegUnits, ~vecs[i].eu);
      repeat (2) @(posedge clock);
      #1;
      check($sformatf("v%0d done pulse ends", i), {7'd0, b1.Done}, 8'd0);
      check($sformatf("v%0d hold units", i), b1.SSegUnits, vecs[i].eu);
      wait_idle();
    end

    do_load(8'd123, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    value = 8'd9; load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    wait_done(lat);
    check("ignored load latency", 8'(lat), 8'd5);
    check_disp("ignored load", 8'hFF, 8'hF9, 8'hA4, 8'hB0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      if (b1.Done) ndone++;
    end
    check("ignored load extra done", 8'(ndone), 8'd0);

    do_load(8'd200, 1'b0, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("abort busy", {7'd0, b1.Busy}, 8'd0);
    check_disp("abort", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    @(posedge clock); #1;
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      if (b1.Done) ndone++;
    end
    check("abort no done", 8'(ndone), 8'd0);
    check("abort units dark", b1.SSegUnits, 8'hFF);

    do_load(8'd255, 1'b0, 1'b0);
    wait_done(lat);
    wait_idle();
    blank = 1'b1;
    do_load(8'd42, 1'b0, 1'b0);
    check_disp("blank early", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wait_done(lat);
    check("blank latency", 8'(lat), 8'd9);
    check_disp("blank at done", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    repeat (2) @(posedge clock);
    #1;
    check_disp("blank held", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    blank = 1'b0;
    @(posedge clock); #1;
    check_disp("blank released", 8'hFF, 8'hFF, 8'h99, 8'hA4);

    value = 8'd7; sgn = 1'b0; ovf = 1'b0; load = 1'b1;
    wait_done(lat);
    check("held load first done", {7'd0, b1.Done}, 8'd1);
    wait_done(lat);
    load = 1'b0;
    check("back-to-back period", 8'(lat), 8'd10);
    check_disp("back-to-back", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
    @(posedge clock); #1;
    check("held load released", {7'd0, b1.Busy}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
